pcs_10g_link_ctrl: RTL and testbench
====================================

PCS_10G_LINK_CTRL -- requirements
Module: pcs_10g_link_ctrl

Interface
REQ-001 Parameter: RST_CYCLES, 16, cycles rx_pcs_rst is held per reset attempt (≥1).
REQ-002 Parameter: LOCK_TIMEOUT, 6440000, cycles allowed in WAIT_LOCK before a retry (≥2).
REQ-003 Parameter: HIBER_TIMEOUT, 6440000, cycles hi_ber may persist in HIBER before a retry (≥2).
REQ-004 Parameter: MAX_RETRY, 8, consecutive failed attempts before FAULT (1..15).
REQ-005 Parameter: POLL_INTERVAL, 1024, cycles between status_read pulses in UP (≥2).
REQ-006 Port: clk  input  1  single clock domain.
REQ-007 Port: rst_n  input  1  asynchronous active-low reset.
REQ-008 Port: enable  input  1  level; 0 forces IDLE.
REQ-009 Port: restart  input  1  one-cycle pulse; leaves FAULT.
REQ-010 Port: block_lock  input  1  from block-lock FSM.
REQ-011 Port: hi_ber  input  1  from BER FSM.
REQ-012 Port: rx_link_up  input  1  debounced link from the BER monitor.
REQ-013 Port: rx_pcs_rst  output  1  active-high RX PCS reset request.
REQ-014 Port: status_read  output  1  one-cycle pulse that clears the monitor's latching-low status.
REQ-015 Port: link_up  output  1  controller considers link operational.
REQ-016 Port: link_fault  output  1  retries exhausted.
REQ-017 Port: state  output  3  current FSM state encoding.
REQ-018 Port: retry_count  output  4  failed attempts since last UP.
REQ-019 Port: link_drop_count  output  16  saturating count of UP exits.

Function
REQ-020 States: IDLE=0, RESET=1, WAIT_LOCK=2, WAIT_LINK=3, UP=4, HIBER=5, FAULT=6. All outputs are registered; state changes one cycle after the qualifying input is sampled.
REQ-021 Priority in every state: enable=0 → IDLE next cycle, ahead of all other transitions. IDLE also clears the timer and retry_count. It does not clear link_drop_count.
REQ-022 IDLE: enable=1 → RESET.
REQ-023 RESET: rx_pcs_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with the timer cleared.
REQ-024 WAIT_LOCK: timer increments each cycle.
- block_lock & ~hi_ber → WAIT_LINK.
- Otherwise, timer reaching LOCK_TIMEOUT-1 is a failed attempt.
- The lock condition wins over a simultaneous timeout.
REQ-025 Failed attempt handling:
- retry_count+1 == MAX_RETRY → FAULT, with retry_count=MAX_RETRY.
- Otherwise retry_count increments and the FSM goes to RESET.
REQ-026 WAIT_LINK:
- rx_link_up=1 → UP, and retry_count clears to 0.
- Loss of block_lock, or hi_ber=1, → WAIT_LOCK with the timer cleared.
REQ-027 UP:
- link_up=1.
- The poll timer emits status_read for one cycle every POLL_INTERVAL cycles, with the first pulse POLL_INTERVAL cycles after entry.
- ~block_lock → WAIT_LOCK.
- Otherwise hi_ber → HIBER.
- Either exit increments link_drop_count (saturating at FFFF).
REQ-028 HIBER: timer increments.
- ~block_lock → WAIT_LOCK (highest priority).
- Otherwise ~hi_ber → WAIT_LINK.
- Otherwise timer reaching HIBER_TIMEOUT-1 is a failed attempt (REQ-025).
REQ-029 FAULT: link_fault=1 and rx_pcs_rst=0. restart=1 → RESET with retry_count cleared. enable=0 still wins.
REQ-030 status_read is 0 in all states other than UP.
REQ-031 link_up is 1 only in UP. rx_pcs_rst is 1 only in RESET.
REQ-032 Timer width is 24 bits, cleared on every state entry, and never wraps within a state.

Reset
REQ-033 rst_n=0 asynchronously sets: state=IDLE, rx_pcs_rst=0, status_read=0, link_up=0, link_fault=0, retry_count=0, link_drop_count=0, timers=0.
REQ-034 Reset assertion mid-RESET terminates the rx_pcs_rst pulse immediately. On release, the FSM restarts from IDLE.

Structure
REQ-035 State encodings and default timing constants live in the shared pcs_10g_pkg.
REQ-036 One sub-module, pcs_10g_link_timer: a loadable 24-bit up-counter with clear and terminal-match output, instantiated twice (state timer, poll timer).

Verification (RST_CYCLES=4, LOCK_TIMEOUT=100, HIBER_TIMEOUT=50, MAX_RETRY=3, POLL_INTERVAL=16)
REQ-037 Normal bring-up:
- Stimulus: enable=1; block_lock=1 at cycle 20; rx_link_up=1 at cycle 40.
- Response: rx_pcs_rst high exactly 4 cycles; state 1→2→3→4; link_up=1; status_read pulses every 16 cycles.
REQ-038 Lock never achieved:
- Stimulus: enable=1, block_lock=0 throughout.
- Response: three attempts of 4+100 cycles; retry_count 1,2,3; then FAULT with link_fault=1.
- Follow-up: restart → RESET with retry_count=0.
REQ-039 hi_ber recovery in UP:
- Stimulus: hi_ber=1 for 20 cycles.
- Response: HIBER, link_drop_count=1, then WAIT_LINK.
- Stimulus: hi_ber=1 for 60 cycles.
- Response: timeout → RESET with retry_count=1.
REQ-040 Simultaneous hi_ber=1 and block_lock=0 in UP → WAIT_LOCK (not HIBER); link_drop_count increments once.
REQ-041 enable deasserted during RESET cycle 2 → IDLE next cycle; rx_pcs_rst drops; retry_count=0.
REQ-042 link_drop_count forced to FFFF plus one more drop → stays at FFFF.

Source files
------------

// File: rtl/pcs_10g_pkg.sv
// rtl/pcs_10g_pkg.sv - shared state encodings and timing defaults for the 10G PCS link controller
package pcs_10g_pkg;

  localparam int TIMER_W = 24;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 6440000;
  localparam int DEF_HIBER_TIMEOUT = 6440000;
  localparam int DEF_MAX_RETRY     = 8;
  localparam int DEF_POLL_INTERVAL = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_WAIT_LINK = 3'd3,
    ST_UP        = 3'd4,
    ST_HIBER     = 3'd5,
    ST_FAULT     = 3'd6
  } link_state_e;

  // Timers count from zero, so a span of N cycles ends when the count reads N-1.
  function automatic logic [TIMER_W-1:0] term_of(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pcs_10g_link_timer.sv
// rtl/pcs_10g_link_timer.sv - loadable 24-bit saturating up-counter with terminal match
module pcs_10g_link_timer
  import pcs_10g_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic               en,
  input  logic [TIMER_W-1:0] load_val,
  input  logic [TIMER_W-1:0] terminal,
  output logic               match
);

  logic [TIMER_W-1:0] count;

  // Holds at all-ones instead of wrapping so a long stay can never re-trigger a match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {TIMER_W{1'b1}})) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign match = (count == terminal);

endmodule

// File: rtl/pcs_10g_link_ctrl.sv
// rtl/pcs_10g_link_ctrl.sv - 10G PCS link bring-up, retry and monitoring controller
module pcs_10g_link_ctrl
  import pcs_10g_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int HIBER_TIMEOUT = DEF_HIBER_TIMEOUT,
  parameter int MAX_RETRY     = DEF_MAX_RETRY,
  parameter int POLL_INTERVAL = DEF_POLL_INTERVAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        restart,
  input  logic        block_lock,
  input  logic        hi_ber,
  input  logic        rx_link_up,
  output logic        rx_pcs_rst,
  output logic        status_read,
  output logic        link_up,
  output logic        link_fault,
  output logic [2:0]  state,
  output logic [3:0]  retry_count,
  output logic [15:0] link_drop_count
);

  link_state_e        state_q;
  link_state_e        next_state;
  logic [3:0]         retry_d;
  logic [15:0]        drops_d;
  logic               fail;
  logic               drop;
  logic               rx_pcs_rst_d;
  logic               status_read_d;
  logic               link_up_d;
  logic               link_fault_d;
  logic               st_clr;
  logic               st_match;
  logic               poll_match;
  logic [TIMER_W-1:0] st_term;

  assign state = state_q;

  always_comb begin
    case (state_q)
      ST_RESET:     st_term = term_of(RST_CYCLES);
      ST_WAIT_LOCK: st_term = term_of(LOCK_TIMEOUT);
      ST_HIBER:     st_term = term_of(HIBER_TIMEOUT);
      default:      st_term = {TIMER_W{1'b1}};
    endcase
  end

  assign st_clr = (next_state != state_q) || (state_q == ST_IDLE);

  pcs_10g_link_timer u_state_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (st_clr),
    .load     (1'b0),
    .en       (state_q != ST_IDLE),
    .load_val ('0),
    .terminal (st_term),
    .match    (st_match)
  );

  // Poll timer idles at zero outside UP and reloads on every pulse.
  pcs_10g_link_timer u_poll_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q != ST_UP),
    .load     (poll_match),
    .en       (1'b1),
    .load_val ('0),
    .terminal (term_of(POLL_INTERVAL)),
    .match    (poll_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      rx_pcs_rst      <= 1'b0;
      status_read     <= 1'b0;
      link_up         <= 1'b0;
      link_fault      <= 1'b0;
      retry_count     <= '0;
      link_drop_count <= '0;
    end else begin
      state_q         <= next_state;
      rx_pcs_rst      <= rx_pcs_rst_d;
      status_read     <= status_read_d;
      link_up         <= link_up_d;
      link_fault      <= link_fault_d;
      retry_count     <= retry_d;
      link_drop_count <= drops_d;
    end
  end

  always_comb begin
    next_state = state_q;
    retry_d    = retry_count;
    drops_d    = link_drop_count;
    fail       = 1'b0;
    drop       = 1'b0;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  next_state = ST_RESET;
        ST_RESET: if (st_match) next_state = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (block_lock && !hi_ber) next_state = ST_WAIT_LINK;
          else if (st_match)         fail = 1'b1;
        end
        ST_WAIT_LINK: begin
          if (rx_link_up) begin
            next_state = ST_UP;
            retry_d    = '0;
          end else if (!block_lock || hi_ber) begin
            next_state = ST_WAIT_LOCK;
          end
        end
        ST_UP: begin
          if (!block_lock) begin
            next_state = ST_WAIT_LOCK;
            drop       = 1'b1;
          end else if (hi_ber) begin
            next_state = ST_HIBER;
            drop       = 1'b1;
          end
        end
        ST_HIBER: begin
          if (!block_lock)   next_state = ST_WAIT_LOCK;
          else if (!hi_ber)  next_state = ST_WAIT_LINK;
          else if (st_match) fail = 1'b1;
        end
        ST_FAULT: begin
          if (restart) begin
            next_state = ST_RESET;
            retry_d    = '0;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
    if (fail) begin
      if (retry_count == 4'(MAX_RETRY - 1)) begin
        next_state = ST_FAULT;
        retry_d    = 4'(MAX_RETRY);
      end else begin
        next_state = ST_RESET;
        retry_d    = retry_count + 4'd1;
      end
    end
    if (drop && (link_drop_count != 16'hFFFF)) drops_d = link_drop_count + 16'd1;
    if (next_state == ST_IDLE) retry_d = '0;
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    rx_pcs_rst_d  = (next_state == ST_RESET);
    link_up_d     = (next_state == ST_UP);
    link_fault_d  = (next_state == ST_FAULT);
    status_read_d = (state_q == ST_UP) && (next_state == ST_UP) && poll_match;
  end

endmodule

// File: tb/tb_pcs_10g_link_ctrl.sv
// tb/tb_pcs_10g_link_ctrl.sv - self-checking bench for pcs_10g_link_ctrl with a cycle model
module tb_pcs_10g_link_ctrl;

  localparam int RST_C   = 4;
  localparam int LOCK_T  = 100;
  localparam int HIBER_T = 50;
  localparam int MAX_R   = 3;
  localparam int POLL    = 16;

  localparam int S_IDLE = 0, S_RESET = 1, S_WLOCK = 2, S_WLINK = 3, S_UP = 4, S_HIBER = 5, S_FAULT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        block_lock = 1'b0;
  logic        hi_ber = 1'b0;
  logic        rx_link_up = 1'b0;
  logic        rx_pcs_rst;
  logic        status_read;
  logic        link_up;
  logic        link_fault;
  logic [2:0]  state;
  logic [3:0]  retry_count;
  logic [15:0] link_drop_count;

  int n_cmp = 0;
  int n_bad = 0;
  int m_state = S_IDLE;
  int m_age = 0;
  int m_retry = 0;
  int m_drops = 0;

  int elapsed, rst_hi, seq, prev, c_up, p1, p2;

  pcs_10g_link_ctrl #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(LOCK_T), .HIBER_TIMEOUT(HIBER_T),
    .MAX_RETRY(MAX_R), .POLL_INTERVAL(POLL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart),
    .block_lock(block_lock), .hi_ber(hi_ber), .rx_link_up(rx_link_up),
    .rx_pcs_rst(rx_pcs_rst), .status_read(status_read), .link_up(link_up),
    .link_fault(link_fault), .state(state), .retry_count(retry_count),
    .link_drop_count(link_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name, output int waited);
    waited = 0;
    while ((int'(state) != s) && (waited < budget)) begin
      tick(1);
      waited++;
    end
    check(name, int'(state), s);
  endtask

  // Spec-level rules: dwell ages, retry bookkeeping, saturating drops.
  task automatic model_step();
    int nxt;
    bit fail;
    bit drop;
    nxt  = m_state;
    fail = 1'b0;
    drop = 1'b0;
    if (!enable) nxt = S_IDLE;
    else begin
      case (m_state)
        S_IDLE:  nxt = S_RESET;
        S_RESET: if (m_age == RST_C - 1) nxt = S_WLOCK;
        S_WLOCK: if (block_lock && !hi_ber) nxt = S_WLINK; else if (m_age == LOCK_T - 1) fail = 1'b1;
        S_WLINK: if (rx_link_up) begin nxt = S_UP; m_retry = 0; end
                 else if (!block_lock || hi_ber) nxt = S_WLOCK;
        S_UP:    if (!block_lock) begin nxt = S_WLOCK; drop = 1'b1; end
                 else if (hi_ber) begin nxt = S_HIBER; drop = 1'b1; end
        S_HIBER: if (!block_lock) nxt = S_WLOCK; else if (!hi_ber) nxt = S_WLINK;
                 else if (m_age == HIBER_T - 1) fail = 1'b1;
        S_FAULT: if (restart) begin nxt = S_RESET; m_retry = 0; end
        default: nxt = S_IDLE;
      endcase
    end
    if (fail) begin
      m_retry++;
      nxt = (m_retry == MAX_R) ? S_FAULT : S_RESET;
    end
    if (drop && m_drops < 65535) m_drops++;
    if (nxt == S_IDLE) m_retry = 0;
    m_age   = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
  endtask

  task automatic compare_cycle();
    logic [26:0] got, exp;
    got = {state, rx_pcs_rst, status_read, link_up, link_fault, retry_count, link_drop_count};
    exp = {3'(m_state), m_state == S_RESET,
           (m_state == S_UP) && (m_age > 0) && (m_age % POLL == 0),
           m_state == S_UP, m_state == S_FAULT, 4'(m_retry), 16'(m_drops)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL cycle_outputs: got %h, expected %h {state,rst,poll,up,fault,retry,drops} (t=%0t)",
               got, exp, $time);
    end
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          m_state = S_IDLE; m_age = 0; m_retry = 0; m_drops = 0;
        end else begin
          model_step();
        end
      end
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    tick(2);
    check("reset_outputs", int'({state, rx_pcs_rst, status_read, link_up, link_fault, retry_count, link_drop_count}), 0);
    rst_n = 1'b1;
    tick(1);

    // Normal bring-up
    enable = 1'b1;
    rst_hi = 0; seq = 0; prev = S_IDLE; c_up = 0; p1 = 0; p2 = 0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 20) block_lock = 1'b1;
      if (c == 40) rx_link_up = 1'b1;
      tick(1);
      if (rx_pcs_rst) rst_hi++;
      if (int'(state) != prev) begin
        seq  = seq * 10 + int'(state);
        prev = int'(state);
        if (prev == S_UP) c_up = c;
      end
      if (status_read) begin
        if (p1 == 0) p1 = c; else if (p2 == 0) p2 = c;
      end
    end
    check("bringup_rst_cycles", rst_hi, 4);
    check("bringup_sequence", seq, 1234);
    check("bringup_up_cycle", c_up, 40);
    check("bringup_link_up", int'(link_up), 1);
    check("poll_first_delay", p1 - c_up, 16);
    check("poll_interval", p2 - p1, 16);

    // Short hi_ber burst in UP
    hi_ber = 1'b1;
    tick(1);
    check("hiber_entry", int'(state), S_HIBER);
    check("hiber_drop_count", int'(link_drop_count), 1);
    tick(19);
    hi_ber = 1'b0;
    tick(1);
    check("hiber_clear_wait_link", int'(state), S_WLINK);
    tick(1);
    check("hiber_back_up", int'(state), S_UP);

    // Long hi_ber burst times out
    hi_ber = 1'b1;
    wait_state(S_RESET, 70, "hiber_timeout_reset", elapsed);
    check("hiber_timeout_cycles", elapsed, 51);
    check("hiber_timeout_retry", int'(retry_count), 1);
    tick(9);
    hi_ber = 1'b0;
    wait_state(S_UP, 20, "recover_after_hiber", elapsed);
    check("retry_cleared_in_up", int'(retry_count), 0);

    // Lock loss and hi_ber together
    hi_ber = 1'b1;
    block_lock = 1'b0;
    tick(1);
    check("lockloss_priority", int'(state), S_WLOCK);
    check("lockloss_drop_once", int'(link_drop_count), 3);
    hi_ber = 1'b0;
    block_lock = 1'b1;
    wait_state(S_UP, 10, "recover_after_lockloss", elapsed);

    // Drop counter saturation
    force dut.link_drop_count = 16'hFFFF;
    m_drops = 65535;
    tick(1);
    release dut.link_drop_count;
    tick(1);
    check("drops_preset", int'(link_drop_count), 65535);
    hi_ber = 1'b1;
    tick(1);
    check("drops_saturate_state", int'(state), S_HIBER);
    check("drops_saturate", int'(link_drop_count), 65535);
    hi_ber = 1'b0;
    wait_state(S_UP, 10, "recover_after_saturate", elapsed);

    enable = 1'b0;
    tick(1);
    check("disable_to_idle", int'(state), S_IDLE);
    check("idle_keeps_drops", int'(link_drop_count), 65535);

    // Lock never achieved
    block_lock = 1'b0;
    rx_link_up = 1'b0;
    enable = 1'b1;
    wait_state(S_FAULT, 400, "fault_reached", elapsed);
    check("fault_cycles", elapsed, 313);
    check("fault_retry", int'(retry_count), 3);
    check("fault_flag", int'(link_fault), 1);
    tick(5);
    check("fault_holds", int'(state), S_FAULT);
    check("fault_no_pcs_rst", int'(rx_pcs_rst), 0);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart_to_reset", int'(state), S_RESET);
    check("restart_retry_clear", int'(retry_count), 0);

    // enable dropped in RESET cycle 2
    wait_state(S_WLOCK, 10, "second_wait_lock", elapsed);
    wait_state(S_RESET, 120, "second_retry", elapsed);
    check("retry_before_disable", int'(retry_count), 1);
    tick(1);
    enable = 1'b0;
    tick(1);
    check("disable_in_reset", int'(state), S_IDLE);
    check("disable_drops_pcs_rst", int'(rx_pcs_rst), 0);
    check("disable_retry_clear", int'(retry_count), 0);

    // Asynchronous reset in the middle of RESET
    enable = 1'b1;
    tick(2);
    check("reset_pulse_active", int'(rx_pcs_rst), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_pcs_rst", int'(rx_pcs_rst), 0);
    check("async_reset_state", int'(state), S_IDLE);
    tick(1);
    rst_n = 1'b1;
    check("idle_after_release", int'(state), S_IDLE);
    tick(1);
    check("restart_from_idle", int'(state), S_RESET);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
